// File: rtl/ifc_pkg.sv
// Shared types for the interface arbiter: FSM states, answer codes and sizing helpers.
package ifc_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_RELEASE = 2'd2,
    S_ALARM   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RESP_OK    = 2'd0,
    RESP_EN    = 2'd1,
    RESP_PE    = 2'd2,
    RESP_ALARM = 2'd3
  } resp_e;

  // Counter must hold the larger of the two tick loads without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  // Parity error dominates engaged, which dominates OK.
  function automatic resp_e answer_code(input logic en, input logic pe);
    if (pe)      return RESP_PE;
    else if (en) return RESP_EN;
    else         return RESP_OK;
  endfunction

endpackage

// File: rtl/ifc_arbiter_if.sv
// Requester/bus bundle between the arbiter (master side) and the requesters plus interface.
interface ifc_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic [1:0]       resp;
    logic             bus_str;
    logic             bus_ok;
    logic             bus_en;
    logic             bus_pe;
    logic             talarm;
    logic             busy;

    modport master (
        input  req, bus_ok, bus_en, bus_pe,
        output gnt, done, resp, bus_str, talarm, busy
    );

    modport slave (
        output req, bus_ok, bus_en, bus_pe,
        input  gnt, done, resp, bus_str, talarm, busy
    );
endinterface

// File: rtl/ifc_rr_pick.sv
// Combinational winner select: round-robin from ptr_i+1, or lowest-index-first
// when IFC_ARB_FIXED_PRIO_EN is defined.
module ifc_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    assign any_o = |req_i;

`ifdef IFC_ARB_FIXED_PRIO_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr_i;

    always_comb begin
        gnt_oh_o = '0;
        idx_o    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                gnt_oh_o    = '0;
                gnt_oh_o[k] = 1'b1;
                idx_o       = IDX_W'(k);
            end
        end
    end
`else
    // Walk from farthest to nearest offset so the closest requester after ptr_i wins.
    always_comb begin
        int j;
        j        = 0;
        gnt_oh_o = '0;
        idx_o    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (req_i[j]) begin
                gnt_oh_o    = '0;
                gnt_oh_o[j] = 1'b1;
                idx_o       = IDX_W'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/ifc_arbiter.sv
// Shares one strobe/answer interface among N_REQ requesters, with no-answer alarm.
// IFC_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module ifc_arbiter
    import ifc_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int ALARM_DLY_TICKS = 50,
    parameter int ALARM_TICKS     = 25
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    ifc_arbiter_if.master ifc
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(ALARM_DLY_TICKS, ALARM_TICKS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    resp_e            resp_q, resp_d;
    logic             str_q, str_d;
    logic [N_REQ-1:0] done_c;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] rr_ptr;
    logic             answer;

    assign answer = ifc.bus_ok | ifc.bus_en | ifc.bus_pe;

`ifdef IFC_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)                            rr_ptr_q <= IDX_W'(N_REQ - 1);
        else if (state_q == S_IDLE && pick_any) rr_ptr_q <= pick_idx;
    end

    assign rr_ptr = rr_ptr_q;
`endif

    ifc_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (ifc.req),
        .ptr_i    (rr_ptr),
        .gnt_oh_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            resp_q  <= RESP_OK;
            str_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            resp_q  <= resp_d;
            str_q   <= str_d;
        end
    end

    // done is combinational so it overlaps the last grant cycle; the winner
    // drops req on that edge and is not re-sampled in the following idle cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        resp_d  = resp_q;
        str_d   = str_q;
        done_c  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_oh;
                    cnt_d   = CNT_W'(ALARM_DLY_TICKS);
                    str_d   = 1'b1;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (answer) begin
                    resp_d  = answer_code(ifc.bus_en, ifc.bus_pe);
                    str_d   = 1'b0;
                    state_d = S_RELEASE;
                end else if (cnt_q == '0) begin
                    resp_d  = RESP_ALARM;
                    str_d   = 1'b0;
                    cnt_d   = CNT_W'(ALARM_TICKS);
                    state_d = S_ALARM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!answer) begin
                    done_c  = gnt_q;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_ALARM: begin
                if (cnt_q == '0) begin
                    done_c  = gnt_q;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ifc.gnt     = gnt_q;
    assign ifc.done    = done_c;
    assign ifc.resp    = resp_q;
    assign ifc.bus_str = str_q;
    assign ifc.talarm  = (state_q == S_ALARM);
    assign ifc.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifc_arbiter.sv
// Scoreboard bench for ifc_arbiter (N_REQ=4, ALARM_DLY_TICKS=8, ALARM_TICKS=4).
module tb_ifc_arbiter;
  localparam int N = 4;

  typedef struct {
    int         idx;
    logic [1:0] resp;
  } exp_t;

  logic clk_sys;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  ifc_arbiter_if #(.N_REQ(N)) ifc ();

  ifc_arbiter #(
    .N_REQ           (N),
    .ALARM_DLY_TICKS (8),
    .ALARM_TICKS     (4)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .ifc     (ifc)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Every done pulse is matched against the oldest expected transaction.
  always @(negedge clk_sys) begin
    if (rst_n && |ifc.done) begin
      exp_t e;
      logic [N-1:0] oh;
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done done=%b resp=%0d", ifc.done, ifc.resp);
      end else begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        if (ifc.done !== oh || ifc.resp !== e.resp || ifc.gnt !== oh) begin
          errors++;
          $display("FAIL sb_done got done=%b gnt=%b resp=%0d want done=%b gnt=%b resp=%0d",
                   ifc.done, ifc.gnt, ifc.resp, oh, oh, e.resp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input int idx, input logic [1:0] resp);
    exp_t e;
    e.idx  = idx;
    e.resp = resp;
    sb.push_back(e);
  endtask

  task automatic wait_str(input string nm);
    int n;
    for (n = 0; n < 20; n++) begin
      cyc();
      if (ifc.bus_str === 1'b1) break;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_str_timeout bus_str=%b want 1", nm, ifc.bus_str);
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk_sys);
      if (|ifc.done) break;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_done_timeout done=%b want pulse", nm, ifc.done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({ifc.gnt, ifc.done, ifc.resp, ifc.bus_str, ifc.talarm, ifc.busy} !== '0) begin
      errors++;
      $display("FAIL reset_state gnt=%b done=%b resp=%0d str=%b talarm=%b busy=%b want all 0",
               ifc.gnt, ifc.done, ifc.resp, ifc.bus_str, ifc.talarm, ifc.busy);
    end
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int order[5];
`ifdef IFC_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    ifc.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[order[i]] = 1'b1;
      push(order[i], 2'd0);
      wait_str("rr");
      checks++;
      if (ifc.gnt !== oh) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got %b want %b", i, ifc.gnt, oh);
      end
      ifc.bus_ok = 1'b1;
      cyc();
      ifc.bus_ok = 1'b0;
      wait_done("rr");
      cyc();
      if (i == 4) ifc.req = '0;
      checks++;
      if (ifc.busy !== 1'b0 || ifc.bus_str !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_gap[%0d] busy=%b str=%b want 0 0", i, ifc.busy, ifc.bus_str);
      end
    end
  endtask

  task automatic test_ok();
    ifc.req = 4'b0001;
    push(0, 2'd0);
    cyc();
    checks++;
    if (ifc.bus_str !== 1'b1 || ifc.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL ok_latency str=%b gnt=%b want 1 0001", ifc.bus_str, ifc.gnt);
    end
    cyc();
    cyc();
    ifc.bus_ok = 1'b1;
    cyc();
    checks++;
    if (ifc.bus_str !== 1'b0 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL ok_str_drop str=%b busy=%b want 0 1", ifc.bus_str, ifc.busy);
    end
    @(negedge clk_sys);
    checks++;
    if (ifc.done !== 4'b0000) begin
      errors++;
      $display("FAIL ok_no_done_while_held done=%b want 0000", ifc.done);
    end
    cyc();
    ifc.bus_ok = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (ifc.done !== 4'b0001) begin
      errors++;
      $display("FAIL ok_done_after_release done=%b want 0001", ifc.done);
    end
    cyc();
    ifc.req = '0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL ok_back_idle busy=%b gnt=%b want 0 0000", ifc.busy, ifc.gnt);
    end
  endtask

  task automatic test_alarm();
    int str_n = 0;
    int al_n  = 0;
    ifc.req = 4'b0001;
    push(0, 2'd3);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_sys);
      str_n += int'(ifc.bus_str);
      al_n  += int'(ifc.talarm);
      if (|ifc.done) break;
    end
    cyc();
    ifc.req = '0;
    checks++;
    if (str_n != 9) begin
      errors++;
      $display("FAIL alarm_str_cycles got %0d want 9", str_n);
    end
    checks++;
    if (al_n != 5) begin
      errors++;
      $display("FAIL alarm_talarm_cycles got %0d want 5", al_n);
    end
    cyc();
    checks++;
    if (ifc.resp !== 2'd3 || ifc.talarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_resp_hold resp=%0d talarm=%b want 3 0", ifc.resp, ifc.talarm);
    end
  endtask

  task automatic test_pe_at_zero();
    ifc.req = 4'b0001;
    push(0, 2'd2);
    wait_str("pe");
    repeat (8) cyc();
    checks++;
    if (ifc.bus_str !== 1'b1 || ifc.talarm !== 1'b0) begin
      errors++;
      $display("FAIL pe_still_strobe str=%b talarm=%b want 1 0", ifc.bus_str, ifc.talarm);
    end
    ifc.bus_en = 1'b1;
    ifc.bus_pe = 1'b1;
    cyc();
    checks++;
    if (ifc.talarm !== 1'b0 || ifc.bus_str !== 1'b0 || ifc.resp !== 2'd2) begin
      errors++;
      $display("FAIL pe_beats_alarm talarm=%b str=%b resp=%0d want 0 0 2",
               ifc.talarm, ifc.bus_str, ifc.resp);
    end
    ifc.bus_en = 1'b0;
    ifc.bus_pe = 1'b0;
    wait_done("pe");
    cyc();
    ifc.req = '0;
  endtask

  task automatic test_drop_req();
    ifc.req = 4'b0100;
    push(2, 2'd0);
    wait_str("drop");
    ifc.req = '0;
    cyc();
    checks++;
    if (ifc.gnt !== 4'b0100 || ifc.bus_str !== 1'b1) begin
      errors++;
      $display("FAIL drop_gnt_kept gnt=%b str=%b want 0100 1", ifc.gnt, ifc.bus_str);
    end
    ifc.bus_ok = 1'b1;
    cyc();
    ifc.bus_ok = 1'b0;
    wait_done("drop");
    cyc();
  endtask

  task automatic test_reset_mid();
    int dc;
    ifc.req = 4'b0001;
    wait_str("rstmid");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.bus_str !== 1'b0 || ifc.gnt !== 4'b0000 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async str=%b gnt=%b busy=%b want 0 0000 0",
               ifc.bus_str, ifc.gnt, ifc.busy);
    end
    dc = done_cnt;
    repeat (3) @(negedge clk_sys);
    @(posedge clk_sys);
    #1;
    rst_n   = 1'b1;
    ifc.req = 4'b0010;
    push(1, 2'd0);
    wait_str("rstmid");
    checks++;
    if (ifc.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_regrant gnt=%b want 0010", ifc.gnt);
    end
    ifc.bus_ok = 1'b1;
    cyc();
    ifc.bus_ok = 1'b0;
    wait_done("rstmid");
    cyc();
    ifc.req = '0;
    checks++;
    if (done_cnt != dc + 1) begin
      errors++;
      $display("FAIL rstmid_done_count got %0d want %0d", done_cnt - dc, 1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ifc.req    = '0;
    ifc.bus_ok = 1'b0;
    ifc.bus_en = 1'b0;
    ifc.bus_pe = 1'b0;
    test_reset();
    test_round_robin();
    test_ok();
    test_alarm();
    test_pe_at_zero();
    test_drop_req();
    test_reset_mid();
    repeat (3) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
